nq_pipe_control: RTL and testbench
==================================

NQ_PIPE_CONTROL -- requirements
Module: nq_pipe_control

Interface
REQ-001 Parameter: REG_ADDR_W, default 3, width of register address fields.
REQ-002 Parameter: CNT_W, default 16, width of stall-cycle counter.
REQ-003 Parameter: MEM_TIMEOUT, default 15, max memory wait cycles before error; 0 disables timeout.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 id_valid  input  1  ID stage holds a valid instruction.
REQ-007 opcode  input  2  ID opcode: 00 rType, 01 iType, 10 jType, 11 bType.
REQ-008 funct  input  3  ID funct: lui 000, lbi 001, sui 010, sbi 011, lw 100, sw 101, others invalid.
REQ-009 rs_addr, rt_addr, rd_addr  input  REG_ADDR_W each  ID source and destination registers.
REQ-010 branch_taken  input  1  EX branch comparison result.
REQ-011 mem_ready  input  1  data memory completes current access this cycle.
REQ-012 stall_flg  output  1  hold PC and IF/ID this cycle.
REQ-013 flush_flg  output  1  squash IF/ID contents this cycle.
REQ-014 ex_jmp_flg, ex_brnch_flg  output  1 each  EX-stage control.
REQ-015 mem_rd_flg, mem_wrt_flg  output  1 each  MEM-stage control.
REQ-016 wb_reg_write_flg  output  1  WB-stage register write enable.
REQ-017 wb_rd_addr  output  REG_ADDR_W  WB destination register.
REQ-018 mem_err_flg  output  1  sticky memory-timeout error.
REQ-019 stall_cnt  output  CNT_W  total stall cycles since reset.

Function
REQ-020 Decode (ID, combinational): rType -> reg_write; lui/lbi -> reg_write; sui/sbi/sw -> mem_wrt; lw -> mem_rd + reg_write; jType -> jmp; bType -> brnch; invalid iType funct or id_valid=0 -> all flags 0 (bubble).
REQ-021 Decoded flags and rd_addr pass through registered ID/EX, EX/MEM, MEM/WB stages; one stage per unstalled cycle; latency ID to WB = 3 cycles.
REQ-022 Load-use hazard: ID/EX holds mem_rd and its rd equals rs_addr or rt_addr of a valid ID instruction -> stall_flg=1, bubble (all flags 0) into ID/EX, EX/MEM and MEM/WB advance; exactly 1 stall cycle per hazard.
REQ-023 Control hazard: ID/EX holds jmp, or brnch with branch_taken=1 -> flush_flg=1 for one cycle, bubble into ID/EX; stall_flg=0.
REQ-024 Memory FSM states RUN, WAIT; RUN->WAIT when EX/MEM holds mem_rd or mem_wrt and mem_ready=0; WAIT->RUN when mem_ready=1 or timeout.
REQ-025 In WAIT, or RUN with pending access and mem_ready=0: stall_flg=1, all stage registers hold, MEM/WB receives bubble.
REQ-026 Wait counter counts cycles in WAIT; reaching MEM_TIMEOUT (non-zero) sets mem_err_flg, forces WAIT->RUN, access dropped as bubble.
REQ-027 Priority: memory stall > control flush > load-use stall; flush suppressed while memory stall active and re-evaluated next cycle.
REQ-028 Simultaneous flush and load-use: flush wins, no stall cycle.
REQ-029 stall_cnt increments each cycle stall_flg=1; saturates at all-ones.
REQ-030 mem_err_flg cleared only by rst.

Reset
REQ-031 rst=1 at clock edge: all stage registers bubble, FSM RUN, wait counter 0, stall_cnt 0, mem_err_flg 0, wb_rd_addr 0.
REQ-032 rst mid-WAIT or mid-hazard: pending access and stall abandoned; stall_flg, flush_flg 0 in first post-reset cycle.

Verification
REQ-033 rType rd=3, mem_ready=1 -> wb_reg_write_flg=1, wb_rd_addr=3 exactly 3 cycles later.
REQ-034 lw rd=2 then rType rs=2 -> stall_flg=1 one cycle, stall_cnt=1, rType reaches WB one cycle late.
REQ-035 bType with branch_taken=1 -> flush_flg=1 one cycle, following instruction never asserts any flag.
REQ-036 sw with mem_ready held 0 for 4 cycles -> stall_flg=1 for 4 cycles, mem_wrt_flg held, stall_cnt=4.
REQ-037 lw with mem_ready held 0, MEM_TIMEOUT=15 -> mem_err_flg=1 after 15 cycles, sticky until rst.
REQ-038 rst asserted during WAIT -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/nq_pipe_control.sv
// nq_pipe_control: pipeline hazard and stage-control unit for a 4-stage
// ID/EX/MEM/WB datapath. It decodes ID, carries control flags through the
// stage registers, and resolves load-use, control and memory-wait hazards.
module nq_pipe_control #(
    parameter int REG_ADDR_W  = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [1:0]            opcode,
    input  logic [2:0]            funct,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  stall_flg,
    output logic                  flush_flg,
    output logic                  ex_jmp_flg,
    output logic                  ex_brnch_flg,
    output logic                  mem_rd_flg,
    output logic                  mem_wrt_flg,
    output logic                  wb_reg_write_flg,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic                  mem_err_flg,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        MEM_RUN,
        MEM_WAIT
    } mem_state_t;

    mem_state_t mem_state, mem_state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

    // decoded ID flags
    logic                  dec_reg_write, dec_mem_rd, dec_mem_wrt, dec_jmp, dec_brnch;
    logic [REG_ADDR_W-1:0] dec_rd;

    // ID/EX stage register
    logic                  idex_reg_write, idex_mem_rd, idex_mem_wrt, idex_jmp, idex_brnch;
    logic [REG_ADDR_W-1:0] idex_rd;

    // EX/MEM stage register
    logic                  exmem_reg_write, exmem_mem_rd, exmem_mem_wrt;
    logic [REG_ADDR_W-1:0] exmem_rd;

    // MEM/WB stage register
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;

    // hazard terms
    logic mem_pending, mem_timeout, mem_stall;
    logic ctrl_flush, load_use, lu_stall;

    // Decode the ID instruction; invalid or absent instructions become bubbles
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_rd    = 1'b0;
        dec_mem_wrt   = 1'b0;
        dec_jmp       = 1'b0;
        dec_brnch     = 1'b0;
        dec_rd        = '0;
        if (id_valid) begin
            unique case (opcode)
                2'b00: dec_reg_write = 1'b1;
                2'b01: begin
                    case (funct)
                        3'b000, 3'b001:         dec_reg_write = 1'b1;
                        3'b010, 3'b011, 3'b101: dec_mem_wrt   = 1'b1;
                        3'b100: begin
                            dec_mem_rd    = 1'b1;
                            dec_reg_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                2'b10: dec_jmp   = 1'b1;
                2'b11: dec_brnch = 1'b1;
                default: ;
            endcase
            if (dec_reg_write || dec_mem_rd || dec_mem_wrt || dec_jmp || dec_brnch)
                dec_rd = rd_addr;
        end
    end

    // Hazard detection with priority: memory stall > control flush > load-use
    always_comb begin
        mem_pending = exmem_mem_rd || exmem_mem_wrt;
        mem_timeout = (MEM_TIMEOUT != 0) && (mem_state == MEM_WAIT) &&
                      (wait_cnt == TIMEOUT_VAL) && mem_pending && !mem_ready;
        mem_stall   = mem_pending && !mem_ready && !mem_timeout;
        ctrl_flush  = !mem_stall && (idex_jmp || (idex_brnch && branch_taken));
        load_use    = id_valid && idex_mem_rd &&
                      ((idex_rd == rs_addr) || (idex_rd == rt_addr));
        lu_stall    = !mem_stall && !ctrl_flush && load_use;
    end

    assign stall_flg        = mem_stall || lu_stall;
    assign flush_flg        = ctrl_flush;
    assign ex_jmp_flg       = idex_jmp;
    assign ex_brnch_flg     = idex_brnch;
    assign mem_rd_flg       = exmem_mem_rd;
    assign mem_wrt_flg      = exmem_mem_wrt;
    assign wb_reg_write_flg = memwb_reg_write;
    assign wb_rd_addr       = memwb_rd;

    // Memory FSM next state and wait-cycle count; the RUN cycle that starts
    // a wait counts as the first waited cycle, so WAIT begins at 1
    always_comb begin
        mem_state_nxt = mem_state;
        wait_cnt_nxt  = wait_cnt;
        case (mem_state)
            MEM_RUN: begin
                if (mem_stall) begin
                    mem_state_nxt = MEM_WAIT;
                    wait_cnt_nxt  = WAIT_W'(1);
                end else begin
                    wait_cnt_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    mem_state_nxt = MEM_RUN;
                    wait_cnt_nxt  = '0;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt  = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                mem_state_nxt = MEM_RUN;
                wait_cnt_nxt  = '0;
            end
        endcase
    end

    // Memory FSM state, wait counter and sticky timeout error
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state   <= MEM_RUN;
            wait_cnt    <= '0;
            mem_err_flg <= 1'b0;
        end else begin
            mem_state <= mem_state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (mem_timeout)
                mem_err_flg <= 1'b1;
        end
    end

    // Stage registers: memory stall holds ID/EX and EX/MEM and bubbles MEM/WB;
    // a timed-out access advances the pipe but is dropped before WB
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_reg_write  <= 1'b0;
            idex_mem_rd     <= 1'b0;
            idex_mem_wrt    <= 1'b0;
            idex_jmp        <= 1'b0;
            idex_brnch      <= 1'b0;
            idex_rd         <= '0;
            exmem_reg_write <= 1'b0;
            exmem_mem_rd    <= 1'b0;
            exmem_mem_wrt   <= 1'b0;
            exmem_rd        <= '0;
            memwb_reg_write <= 1'b0;
            memwb_rd        <= '0;
        end else if (mem_stall) begin
            memwb_reg_write <= 1'b0;
            memwb_rd        <= '0;
        end else begin
            if (mem_timeout) begin
                memwb_reg_write <= 1'b0;
                memwb_rd        <= '0;
            end else begin
                memwb_reg_write <= exmem_reg_write;
                memwb_rd        <= exmem_rd;
            end
            exmem_reg_write <= idex_reg_write;
            exmem_mem_rd    <= idex_mem_rd;
            exmem_mem_wrt   <= idex_mem_wrt;
            exmem_rd        <= idex_rd;
            if (ctrl_flush || lu_stall) begin
                idex_reg_write <= 1'b0;
                idex_mem_rd    <= 1'b0;
                idex_mem_wrt   <= 1'b0;
                idex_jmp       <= 1'b0;
                idex_brnch     <= 1'b0;
                idex_rd        <= '0;
            end else begin
                idex_reg_write <= dec_reg_write;
                idex_mem_rd    <= dec_mem_rd;
                idex_mem_wrt   <= dec_mem_wrt;
                idex_jmp       <= dec_jmp;
                idex_brnch     <= dec_brnch;
                idex_rd        <= dec_rd;
            end
        end
    end

    // Saturating count of stalled cycles since reset
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_flg && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_nq_pipe_control.sv
// tb_nq_pipe_control: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural pipeline model held in the bench.
module tb_nq_pipe_control;

    localparam int AW = 3;
    localparam int CW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst, id_valid, branch_taken, mem_ready;
    logic [1:0]    opcode;
    logic [2:0]    funct;
    logic [AW-1:0] rs_addr, rt_addr, rd_addr;
    logic          stall_flg, flush_flg, ex_jmp_flg, ex_brnch_flg;
    logic          mem_rd_flg, mem_wrt_flg, wb_reg_write_flg, mem_err_flg;
    logic [AW-1:0] wb_rd_addr;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    nq_pipe_control #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .opcode          (opcode),
        .funct           (funct),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rd_addr         (rd_addr),
        .branch_taken    (branch_taken),
        .mem_ready       (mem_ready),
        .stall_flg       (stall_flg),
        .flush_flg       (flush_flg),
        .ex_jmp_flg      (ex_jmp_flg),
        .ex_brnch_flg    (ex_brnch_flg),
        .mem_rd_flg      (mem_rd_flg),
        .mem_wrt_flg     (mem_wrt_flg),
        .wb_reg_write_flg(wb_reg_write_flg),
        .wb_rd_addr      (wb_rd_addr),
        .mem_err_flg     (mem_err_flg),
        .stall_cnt       (stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // st[0]=instruction in EX, st[1]=in MEM, st[2]=in WB
    typedef struct {
        bit rw, mr, mw, j, b;
        int rd;
    } ins_t;

    ins_t st[3];
    int   waited;   // stall cycles already spent on the access in MEM
    bit   err;
    int   scount;
    bit   live = 1'b0;
    bit   m_stall, m_flush, m_mstall, m_to, m_lu;

    function automatic ins_t bubble();
        ins_t x;
        x = '{rw: 0, mr: 0, mw: 0, j: 0, b: 0, rd: 0};
        return x;
    endfunction

    function automatic ins_t decode();
        ins_t x;
        x = bubble();
        if (id_valid) begin
            if (opcode == 2'd0) x.rw = 1;
            if (opcode == 2'd2) x.j = 1;
            if (opcode == 2'd3) x.b = 1;
            if (opcode == 2'd1) begin
                if (funct == 3'd0 || funct == 3'd1) x.rw = 1;
                if (funct == 3'd2 || funct == 3'd3 || funct == 3'd5) x.mw = 1;
                if (funct == 3'd4) begin x.mr = 1; x.rw = 1; end
            end
            if (x.rw || x.mr || x.mw || x.j || x.b) x.rd = int'(rd_addr);
        end
        return x;
    endfunction

    function automatic void derive();
        bit pending;
        pending  = st[1].mr || st[1].mw;
        m_to     = pending && !mem_ready && (TO != 0) && (waited == TO);
        m_mstall = pending && !mem_ready && !m_to;
        m_flush  = !m_mstall && (st[0].j || (st[0].b && branch_taken));
        m_lu     = id_valid && st[0].mr &&
                   (st[0].rd == int'(rs_addr) || st[0].rd == int'(rt_addr));
        m_stall  = m_mstall || (m_lu && !m_flush);
    endfunction

    // Model advances on the same edge as the DUT; inputs are stable there
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) st[i] = bubble();
            waited = 0;
            err    = 0;
            scount = 0;
            live   = 1;
        end else if (live) begin
            derive();
            if (m_stall && scount < (1 << CW) - 1) scount++;
            if (m_mstall) begin
                st[2] = bubble();
                waited++;
            end else begin
                st[2] = m_to ? bubble() : st[1];
                st[1] = st[0];
                st[0] = (m_flush || m_lu) ? bubble() : decode();
                waited = 0;
                if (m_to) err = 1;
            end
        end
    end

    // Single compare process: every output, every cycle, mid-period
    always @(negedge clk) begin
        if (live) begin
            derive();
            chk("stall_flg",   int'(stall_flg),        int'(m_stall));
            chk("flush_flg",   int'(flush_flg),        int'(m_flush));
            chk("ex_jmp",      int'(ex_jmp_flg),       int'(st[0].j));
            chk("ex_brnch",    int'(ex_brnch_flg),     int'(st[0].b));
            chk("mem_rd",      int'(mem_rd_flg),       int'(st[1].mr));
            chk("mem_wrt",     int'(mem_wrt_flg),      int'(st[1].mw));
            chk("wb_rw",       int'(wb_reg_write_flg), int'(st[2].rw));
            chk("wb_rd_addr",  int'(wb_rd_addr),       st[2].rd);
            chk("mem_err",     int'(mem_err_flg),      int'(err));
            chk("stall_cnt",   int'(stall_cnt),        scount);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(bit v, bit [1:0] op, bit [2:0] fn, int rs, int rt, int rd,
                         bit bt, bit mr, bit r);
        @(posedge clk);
        #2;
        id_valid     = v;
        opcode       = op;
        funct        = fn;
        rs_addr      = AW'(rs);
        rt_addr      = AW'(rt);
        rd_addr      = AW'(rd);
        branch_taken = bt;
        mem_ready    = mr;
        rst          = r;
    endtask

    task automatic idle(bit mr);
        apply(0, 2'd0, 3'd0, 0, 0, 0, 0, mr, 0);
    endtask

    task automatic do_reset();
        apply(0, 2'd0, 3'd0, 0, 0, 0, 0, 1, 1);
        apply(0, 2'd0, 3'd0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    int burst;

    initial begin
        rst = 1; id_valid = 0; opcode = 0; funct = 0; rs_addr = 0; rt_addr = 0;
        rd_addr = 0; branch_taken = 0; mem_ready = 1;
        do_reset();

        // reset state
        idle(1); sample();
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_wb_rd", int'(wb_rd_addr), 0);
        chk("rst_err", int'(mem_err_flg), 0);
        chk("rst_stall", int'(stall_flg), 0);

        // rType rd=3 reaches WB exactly 3 cycles later
        apply(1, 2'd0, 3'd0, 1, 1, 3, 0, 1, 0);
        idle(1); idle(1); sample();
        chk("rtype_wb_early", int'(wb_reg_write_flg), 0);
        idle(1); sample();
        chk("rtype_wb_rw", int'(wb_reg_write_flg), 1);
        chk("rtype_wb_rd", int'(wb_rd_addr), 3);

        // lw rd=2 then rType rs=2: one stall cycle, rType lands one cycle late
        do_reset();
        apply(1, 2'd1, 3'd4, 0, 0, 2, 0, 1, 0);
        apply(1, 2'd0, 3'd0, 2, 5, 4, 0, 1, 0); sample();
        chk("lu_stall", int'(stall_flg), 1);
        apply(1, 2'd0, 3'd0, 2, 5, 4, 0, 1, 0); sample();
        chk("lu_no_2nd_stall", int'(stall_flg), 0);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        idle(1); sample();
        chk("lu_lw_wb_rd", int'(wb_rd_addr), 2);
        idle(1); sample();
        chk("lu_gap_wb", int'(wb_reg_write_flg), 0);
        idle(1); sample();
        chk("lu_rtype_wb_rw", int'(wb_reg_write_flg), 1);
        chk("lu_rtype_wb_rd", int'(wb_rd_addr), 4);

        // taken branch flushes the following lw
        do_reset();
        apply(1, 2'd3, 3'd0, 0, 0, 1, 0, 1, 0);
        apply(1, 2'd1, 3'd4, 6, 6, 5, 1, 1, 0); sample();
        chk("br_flush", int'(flush_flg), 1);
        chk("br_no_stall", int'(stall_flg), 0);
        idle(1); sample();
        chk("br_flush_once", int'(flush_flg), 0);
        chk("br_ex_brnch_gone", int'(ex_brnch_flg), 0);
        idle(1); sample();
        chk("br_squashed_mem_rd", int'(mem_rd_flg), 0);
        idle(1); sample();
        chk("br_squashed_wb", int'(wb_reg_write_flg), 0);

        // sw with mem_ready low for 4 cycles
        do_reset();
        apply(1, 2'd1, 3'd5, 0, 0, 1, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            idle(0); sample();
            chk("sw_wait_stall", int'(stall_flg), 1);
            chk("sw_wait_wrt", int'(mem_wrt_flg), 1);
        end
        idle(1); sample();
        chk("sw_done_stall", int'(stall_flg), 0);
        chk("sw_stall_cnt", int'(stall_cnt), 4);

        // lw that never completes: timeout after 15 stall cycles, error sticky
        do_reset();
        apply(1, 2'd1, 3'd4, 0, 0, 1, 0, 1, 0);
        idle(1);
        for (int i = 0; i < TO; i++) begin
            idle(0); sample();
            chk("to_wait_stall", int'(stall_flg), 1);
        end
        idle(0); sample();
        chk("to_release_stall", int'(stall_flg), 0);
        chk("to_err_pending", int'(mem_err_flg), 0);
        idle(0); sample();
        chk("to_err_set", int'(mem_err_flg), 1);
        chk("to_stall_cnt", int'(stall_cnt), 15);
        chk("to_dropped_wb", int'(wb_reg_write_flg), 0);
        for (int i = 0; i < 4; i++) idle(1);
        sample();
        chk("to_err_sticky", int'(mem_err_flg), 1);

        // reset in the middle of a memory wait
        apply(1, 2'd1, 3'd4, 0, 0, 2, 0, 1, 0);
        idle(1); idle(0); idle(0); sample();
        chk("rw_in_wait", int'(stall_flg), 1);
        apply(0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 1);
        idle(0); sample();
        chk("rw_stall", int'(stall_flg), 0);
        chk("rw_flush", int'(flush_flg), 0);
        chk("rw_err", int'(mem_err_flg), 0);
        chk("rw_cnt", int'(stall_cnt), 0);
        chk("rw_mem_rd", int'(mem_rd_flg), 0);
        chk("rw_wb_rd", int'(wb_rd_addr), 0);

        // randomized traffic
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            bit mr;
            if (burst > 0) begin
                mr = 0;
                burst--;
            end else begin
                mr = ($urandom % 8) != 0;
                if ($urandom % 100 == 0) burst = $urandom_range(8, 20);
            end
            apply(($urandom % 4) != 0, 2'($urandom), 3'($urandom),
                  int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
                  1'($urandom), mr, ($urandom % 400) == 0);
        end
        idle(1); idle(1); sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
